// File: rtl/llc_arb_pkg.sv
// Shared constants, decode entry type and arbitration helpers for the LLC input arbiter.
package llc_arb_pkg;

  localparam int unsigned LINE_ADDR_BITS = 26;
  localparam int unsigned LLC_SET_BITS   = 10;
  localparam int unsigned LLC_TAG_BITS   = LINE_ADDR_BITS - LLC_SET_BITS;
  localparam int unsigned ARB_NUM_CH     = 6;

  typedef struct packed {
    logic [ARB_NUM_CH-1:0]   ch;
    logic [LLC_TAG_BITS-1:0] tag;
    logic [LLC_SET_BITS-1:0] set;
  } arb_entry_t;

  function automatic logic [ARB_NUM_CH-1:0] onehot_lowest(input logic [ARB_NUM_CH-1:0] v);
    logic [ARB_NUM_CH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ARB_NUM_CH; i++)
      if (v[i] && r == '0) r[i] = 1'b1;
    return r;
  endfunction

  // Cyclic search from ptr within [base, n-1]: try [ptr, n-1] first, then [base, ptr-1].
  function automatic logic [ARB_NUM_CH-1:0] rr_pick(input logic [ARB_NUM_CH-1:0] v,
                                                     input int unsigned ptr,
                                                     input int unsigned base,
                                                     input int unsigned n);
    logic [ARB_NUM_CH-1:0] hi, lo;
    hi = '0;
    lo = '0;
    for (int unsigned j = 0; j < ARB_NUM_CH; j++) begin
      hi[j] = v[j] && (j >= base) && (j >= ptr) && (j < n);
      lo[j] = v[j] && (j >= base) && (j < ptr);
    end
    return (hi != '0) ? onehot_lowest(hi) : onehot_lowest(lo);
  endfunction

endpackage

// File: rtl/llc_arb_fifo.sv
// Generic synchronous FIFO with flush; head entry is driven straight from storage.
module llc_arb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [PW-1:0]  head, tail;
  logic           do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign dout   = mem[head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= nxt(tail);
      end
      if (do_pop) head <= nxt(head);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC front-end arbiter: strict + round-robin channel select into a decode FIFO.
// Optional wait-counter aging is compiled in with LLC_ARB_AGING_EN.
module llc_input_arbiter
  import llc_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = ARB_NUM_CH,
  parameter int unsigned RR_BASE  = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_valid,
  input  logic [NUM_CH-1:0]                ch_block,
  input  logic [NUM_CH*LINE_ADDR_BITS-1:0] ch_addr,
  input  logic                             flush,
  input  logic                             out_pop,
  output logic [NUM_CH-1:0]                ch_get,
  output logic                             out_valid,
  output logic [NUM_CH-1:0]                out_ch,
  output logic [LLC_SET_BITS-1:0]          out_set,
  output logic [LLC_TAG_BITS-1:0]          out_tag,
  output logic                             full,
  output logic                             idle
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [NUM_CH-1:0]         eligible, grant, strict_mask;
  logic [PTR_W-1:0]          rr_ptr;
  logic [CNT_W-1:0]          count;
  logic                      can_push, push, rr_grant;
  logic [LINE_ADDR_BITS-1:0] win_addr;
  int unsigned               win_idx;
  arb_entry_t                din, dout;

  assign eligible = ch_valid & ~ch_block;
  assign can_push = (count < CNT_W'(DEPTH)) || (out_pop && count != '0);
  assign push     = rst && !flush && can_push && (eligible != '0);
  assign ch_get   = push ? grant : '0;
  assign rr_grant = (grant & ~strict_mask) != '0;

`ifdef LLC_ARB_AGING_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT+1);
  logic [WAIT_W-1:0] wait_cnt [NUM_CH];
  logic [NUM_CH-1:0] aged;

  always_comb begin
    aged = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      aged[i] = eligible[i] && (wait_cnt[i] == WAIT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!rst || !eligible[i] || ch_get[i]) wait_cnt[i] <= '0;
      else if (wait_cnt[i] != WAIT_W'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
    end
  end
`else
  // Aging threshold has no effect in this build.
  if (MAX_WAIT == 0) begin : g_no_aging
  end
`endif

  always_comb begin
    strict_mask = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) strict_mask[i] = (i < RR_BASE);
    if ((eligible & strict_mask) != '0)
      grant = NUM_CH'(onehot_lowest(ARB_NUM_CH'(eligible & strict_mask)));
    else
      grant = NUM_CH'(rr_pick(ARB_NUM_CH'(eligible), int'(rr_ptr), RR_BASE, NUM_CH));
`ifdef LLC_ARB_AGING_EN
    if (aged != '0) grant = NUM_CH'(onehot_lowest(ARB_NUM_CH'(aged)));
`endif
  end

  always_comb begin
    win_idx  = 0;
    win_addr = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (grant[j]) begin
        win_idx  = j;
        win_addr = ch_addr[j*LINE_ADDR_BITS +: LINE_ADDR_BITS];
      end
    end
    din.ch  = ARB_NUM_CH'(grant);
    din.set = win_addr[LLC_SET_BITS-1:0];
    din.tag = win_addr[LINE_ADDR_BITS-1:LLC_SET_BITS];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= PTR_W'(RR_BASE);
      idle   <= 1'b1;
    end else begin
      idle <= (eligible == '0);
      if (push && rr_grant)
        rr_ptr <= (win_idx + 1 >= NUM_CH) ? PTR_W'(RR_BASE) : PTR_W'(win_idx + 1);
    end
  end

  llc_arb_fifo #(
    .DEPTH (DEPTH),
    .T     (arb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (out_pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign out_ch    = NUM_CH'(dout.ch);
  assign out_set   = dout.set;
  assign out_tag   = dout.tag;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Directed self-checking bench for llc_input_arbiter (aging case follows LLC_ARB_AGING_EN).
module tb_llc_input_arbiter;
  import llc_arb_pkg::*;

  localparam int unsigned NUM_CH = 6;
`ifdef LLC_ARB_AGING_EN
  localparam int unsigned MW = 3;
`else
  localparam int unsigned MW = 15;
`endif

  logic                             clk, rst, flush, out_pop;
  logic [NUM_CH-1:0]                ch_valid, ch_block, ch_get, out_ch;
  logic [NUM_CH*LINE_ADDR_BITS-1:0] ch_addr;
  logic                             out_valid, full, idle;
  logic [LLC_SET_BITS-1:0]          out_set;
  logic [LLC_TAG_BITS-1:0]          out_tag;

  int tests = 0;
  int fails = 0;

  llc_input_arbiter #(
    .NUM_CH   (NUM_CH),
    .RR_BASE  (4),
    .DEPTH    (2),
    .MAX_WAIT (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_block  (ch_block),
    .ch_addr   (ch_addr),
    .flush     (flush),
    .out_pop   (out_pop),
    .ch_get    (ch_get),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_set   (out_set),
    .out_tag   (out_tag),
    .full      (full),
    .idle      (idle)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_age [5];
    logic [5:0] exp_rr  [4];
    exp_rr = '{6'b010000, 6'b100000, 6'b010000, 6'b100000};
`ifdef LLC_ARB_AGING_EN
    exp_age = '{6'b000001, 6'b000001, 6'b000001, 6'b100000, 6'b000001};
`else
    exp_age = '{6'b000001, 6'b000001, 6'b000001, 6'b000001, 6'b000001};
`endif

    rst = 0; flush = 0; out_pop = 0; ch_valid = '0; ch_block = '0;
    ch_addr = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_addr[i*LINE_ADDR_BITS +: LINE_ADDR_BITS] = 26'h0155000 + 26'(i * 26'h0040321);
    ch_addr[1*LINE_ADDR_BITS +: LINE_ADDR_BITS] = 26'h2ABC123;

    // Reset
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_set", out_set, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_ch_get", ch_get, 0);
    check("rst_full", full, 0);
    check("rst_idle", idle, 1);
    check("rst_rr_ptr", dut.rr_ptr, 4);
    rst = 1;

    // Strict lowest index, then split address on the head entry
    ch_valid = 6'b000110;
    #1 check("strict_get", ch_get, 6'b000010);
    step();
    ch_valid = '0;
    check("head_valid", out_valid, 1);
    check("head_ch", out_ch, 6'b000010);
    check("head_set", out_set, 10'h123);
    check("head_tag", out_tag, 16'hAAF0);
    check("busy_idle", idle, 0);
    out_pop = 1;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_idle", idle, 1);
    step();
    check("pop_empty_count", dut.u_fifo.count, 0);

    // Blocked channel is skipped
    ch_valid = 6'b000011; ch_block = 6'b000001;
    #1 check("block_get", ch_get, 6'b000010);
    step();
    ch_valid = '0; ch_block = '0;
    check("block_head_ch", out_ch, 6'b000010);
    step();
    check("block_drain", out_valid, 0);

    // Round robin alternation with continuous pop
    ch_valid = 6'b110000;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_get%0d", k), ch_get, exp_rr[k]);
      step();
    end
    ch_valid = '0;
    check("rr_ptr_wrap", dut.rr_ptr, 4);
    step();
    check("rr_drain", out_valid, 0);

    // Strict beats round robin and leaves rr_ptr alone
    ch_valid = 6'b110001;
    #1 check("strict_over_rr", ch_get, 6'b000001);
    step();
    ch_valid = '0;
    check("strict_rr_ptr", dut.rr_ptr, 4);
    step();

    // Fill to DEPTH, then push while popping when full
    out_pop = 0;
    ch_valid = 6'b000001;
    #1 check("fill_get0", ch_get, 6'b000001);
    step();
    check("fill_get1", ch_get, 6'b000001);
    step();
    check("full_flag", full, 1);
    check("full_get", ch_get, 0);
    check("full_count", dut.u_fifo.count, 2);
    out_pop = 1;
    #1 check("full_pop_get", ch_get, 6'b000001);
    step();
    out_pop = 0;
    check("full_pop_count", dut.u_fifo.count, 2);
    check("full_pop_full", full, 1);

    // Flush wins over push
    flush = 1;
    #1 check("flush_get", ch_get, 0);
    step();
    flush = 0; ch_valid = '0;
    check("flush_valid", out_valid, 0);
    check("flush_count", dut.u_fifo.count, 0);
    check("flush_full", full, 0);
    step();

    // Aging: ch5 starved by ch0
    ch_valid = 6'b100001; out_pop = 1;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("age_get%0d", k), ch_get, exp_age[k]);
      step();
    end
    ch_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
Parametrised front-end arbiter for the LLC pipeline. It selects one of NUM_CH incoming message channels per cycle (rsp, req, dma, rst, and resume sources) using mixed strict-priority and round-robin classes. It splits the winning line address into set and tag, then buffers the decision in a DEPTH-entry decode FIFO. The lookup stage drains the FIFO, decoupling arbitration from set read.

Parameters:
NUM_CH, 6, number of input channels; index 0 is the highest strict priority.
RR_BASE, 4, channels with index >= RR_BASE form one round-robin class; this class sits below all strict channels.
DEPTH, 2, decode FIFO entries (>= 1).
MAX_WAIT, 15, aging threshold in cycles; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
ch_valid  in  NUM_CH  per-channel request valid
ch_block  in  NUM_CH  per-channel stall mask (req_stall, dma pending, and similar); a blocked channel is ineligible
ch_addr  in  NUM_CH*LINE_ADDR_BITS  line address per channel; channel i occupies bits [i*LINE_ADDR_BITS +: LINE_ADDR_BITS]
flush  in  1  synchronous FIFO clear
out_pop  in  1  consumer pops the head entry
ch_get  out  NUM_CH  one-hot dequeue pulse to the granted channel, same cycle as the push
out_valid  out  1  FIFO non-empty
out_ch  out  NUM_CH  one-hot channel of the head entry
out_set  out  LLC_SET_BITS  set of the head entry
out_tag  out  LLC_TAG_BITS  tag of the head entry
full  out  1  FIFO count == DEPTH
idle  out  1  registered; 1 when no channel was eligible in the previous cycle

Behaviour:
- Reset (rst==0 at posedge clk): count=0, head/tail=0, rr_ptr=RR_BASE, idle=1. out_valid=0, out_ch=0, out_set=0, out_tag=0, ch_get=0, full=0.
- eligible = ch_valid & ~ch_block.
- can_push = (count<DEPTH) || (out_pop && count!=0).
- grant: computed combinationally.
  - If any eligible channel has index < RR_BASE, the lowest such index wins.
  - Otherwise the first eligible channel at or after rr_ptr wins, searching cyclically within [RR_BASE, NUM_CH-1].
- When eligible != 0, can_push, and !flush:
  - push {onehot, tag, set}.
  - ch_get = onehot in the same cycle.
  - set = addr[LLC_SET_BITS-1:0]; tag = addr[LINE_ADDR_BITS-1:LLC_SET_BITS].
- If the push cannot happen, ch_get=0 and the channel holds its valid. There is no loss and no duplicate grant.
- rr_ptr update: after a round-robin grant to channel w, rr_ptr = w+1, wrapping to RR_BASE past NUM_CH-1. A strict grant leaves rr_ptr unchanged.
- FIFO latency: a pushed entry is visible on out_* the next cycle. There is no same-cycle bypass.
- out_pop when count==0 is ignored. Push and pop in the same cycle keep count unchanged; this is legal when full.
- flush: count=0 and pointers=0 next cycle. flush has priority over push and pop. ch_get=0 during flush. rr_ptr is kept.
- idle <= (eligible==0) every cycle, regardless of full.
- out_* are driven from storage and are not gated by out_valid. Bench checks them only when out_valid=1.
- Reset mid-operation discards FIFO contents. Channels must re-present their requests.

Optional Feature:
LLC_ARB_AGING_EN.
- Compiled in: each channel has a wait counter of width clog2(MAX_WAIT+1).
  - The counter increments (saturating) while the channel is eligible but not granted, and clears on grant or when the channel is ineligible.
  - Any channel with counter==MAX_WAIT is "aged". The lowest-index aged channel overrides both priority classes.
  - An aged round-robin winner still updates rr_ptr.
- Compiled out: no counters; pure strict + round-robin arbitration.

Decomposition:
- Shared package llc_arb_pkg: arb_entry_t {onehot ch, set, tag}, plus helper functions onehot_lowest() and rr_pick().
- Reuse LINE_ADDR_BITS, LLC_SET_BITS, and LLC_TAG_BITS from the cache constants.
- One natural sub-module: llc_arb_fifo, a generic synchronous FIFO parametrised by DEPTH and type, with flush.

Test Plan:
- Reset default params; assert rst=0 for 2 cycles -> all outputs 0, idle=1, rr_ptr=4.
- ch_valid=6'b000110, FIFO empty -> ch_get=6'b000010. Next cycle out_valid=1, out_ch=6'b000010, out_set/out_tag equal ch_addr[1] split.
- ch_valid=6'b110000 held, out_pop=1 every cycle -> grants alternate ch4, ch5, ch4, and so on.
- Fill DEPTH=2 with no pop -> full=1 and ch_get=0. Then out_pop=1 with ch_valid set -> push accepted, count stays 2.
- flush=1 with count=2 and ch_valid=1 -> ch_get=0; next cycle out_valid=0, count=0.
- With LLC_ARB_AGING_EN and MAX_WAIT=3: ch5 valid and ch0 valid continuously -> ch5 is granted on the 4th cycle, then ch0 resumes.
